store_buffer: RTL and testbench

Posted-write buffer between the datapath store path and the 16-bit data memory, the write-side counterpart of the memory data selector on the read side. It accepts store requests (address, data) from the datapath with a valid/ready handshake and queues them in a small FIFO. It drains the FIFO to memory through a write/acknowledge interface. It also provides read-after-write forwarding, so the read-side selector returns buffered data for a load that targets a pending store.

---
 rtl/store_buffer_pkg.sv | 13 +
 rtl/store_fifo.sv | 73 +++++++
 rtl/store_buffer.sv | 105 ++++++++++
 tb/tb_store_buffer.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/store_buffer_pkg.sv
// Shared definitions for the store buffer and the read-side selector that consumes its
// forwarding result.
package store_buffer_pkg;

  localparam int unsigned AW_DEFAULT = 16;
  localparam int unsigned DW_DEFAULT = 16;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_WRITE = 1'b1
  } drain_state_e;

endpackage

// File: rtl/store_fifo.sv
// Circular store queue: entry storage, pointers and occupancy count.
// The full entry array is exposed so the top level can do forwarding.
module store_fifo
  import store_buffer_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned AW    = AW_DEFAULT,
  parameter int unsigned DW    = DW_DEFAULT,
  localparam int unsigned PW   = $clog2(DEPTH),
  localparam int unsigned CW   = $clog2(DEPTH) + 1
) (
  input  logic                       CLK,
  input  logic                       Reset,
  input  logic                       push,
  input  logic [AW-1:0]              push_addr,
  input  logic [DW-1:0]              push_data,
  input  logic                       pop,
  output logic [AW-1:0]              head_addr,
  output logic [DW-1:0]              head_data,
  output logic                       full,
  output logic                       empty,
  output logic [CW-1:0]              count,
  output logic [CW-1:0]              count_next,
  output logic [PW-1:0]              wr_ptr,
  output logic [DEPTH-1:0][AW-1:0]   ent_addr,
  output logic [DEPTH-1:0][DW-1:0]   ent_data
);

  logic [PW-1:0]             wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]             count_q, count_d;
  logic [DEPTH-1:0][AW-1:0]  addr_q;
  logic [DEPTH-1:0][DW-1:0]  data_q;

  always_comb begin
    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (Reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
      count_q <= count_d;
    end
  end

  // Storage needs no reset; validity is tracked by count and pointers alone.
  always_ff @(posedge CLK) begin
    if (push) begin
      addr_q[wr_ptr_q] <= push_addr;
      data_q[wr_ptr_q] <= push_data;
    end
  end

  assign head_addr  = addr_q[rd_ptr_q];
  assign head_data  = data_q[rd_ptr_q];
  assign full       = (count_q == CW'(DEPTH));
  assign empty      = (count_q == '0);
  assign count      = count_q;
  assign count_next = count_d;
  assign wr_ptr     = wr_ptr_q;
  assign ent_addr   = addr_q;
  assign ent_data   = data_q;

endmodule

// File: rtl/store_buffer.sv
// Posted-write buffer: queues datapath stores, drains them to data memory with a
// write/ack handshake, and forwards pending store data to loads.
module store_buffer
  import store_buffer_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned AW    = AW_DEFAULT,
  parameter int unsigned DW    = DW_DEFAULT
) (
  input  logic          CLK,
  input  logic          Reset,
  input  logic          st_valid,
  input  logic [AW-1:0] st_addr,
  input  logic [DW-1:0] st_data,
  output logic          st_ready,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic          mem_ack,
  input  logic [AW-1:0] rd_addr,
  output logic          fwd_hit,
  output logic [DW-1:0] fwd_data,
  output logic          empty
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH) + 1;

  drain_state_e              state_q, state_d;
  logic                      push, pop, full, fifo_empty;
  logic [AW-1:0]             head_addr;
  logic [DW-1:0]             head_data;
  logic [CW-1:0]             count, count_next;
  logic [PW-1:0]             wr_ptr;
  logic [DEPTH-1:0][AW-1:0]  ent_addr;
  logic [DEPTH-1:0][DW-1:0]  ent_data;

  assign st_ready = ~full;
  assign push     = st_valid & ~full;
  assign pop      = (state_q == ST_WRITE) & mem_ack;

  store_fifo #(
    .DEPTH (DEPTH),
    .AW    (AW),
    .DW    (DW)
  ) u_fifo (
    .CLK        (CLK),
    .Reset      (Reset),
    .push       (push),
    .push_addr  (st_addr),
    .push_data  (st_data),
    .pop        (pop),
    .head_addr  (head_addr),
    .head_data  (head_data),
    .full       (full),
    .empty      (fifo_empty),
    .count      (count),
    .count_next (count_next),
    .wr_ptr     (wr_ptr),
    .ent_addr   (ent_addr),
    .ent_data   (ent_data)
  );

  // Decisions use the next count so a push into an empty buffer writes the following cycle.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:  if (count_next != '0) state_d = ST_WRITE;
      ST_WRITE: if (count_next == '0) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (Reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  assign mem_we    = (state_q == ST_WRITE);
  assign mem_addr  = mem_we ? head_addr : '0;
  assign mem_wdata = mem_we ? head_data : '0;
  assign empty     = fifo_empty & (state_q == ST_IDLE);

  // Slot k holds the (k+1)-th youngest entry; it is valid while k < count.
  logic [DEPTH-1:0]          match;
  logic [DEPTH-1:0][PW-1:0]  fidx;

  for (genvar k = 0; k < DEPTH; k++) begin : g_fwd
    assign fidx[k]  = wr_ptr - PW'(k + 1);
    assign match[k] = (CW'(k) < count) && (ent_addr[fidx[k]] == rd_addr);
  end

  // Scan oldest to youngest so the youngest match is the last to win.
  always_comb begin
    fwd_hit  = 1'b0;
    fwd_data = '0;
    for (int k = int'(DEPTH) - 1; k >= 0; k--) begin
      if (match[k]) begin
        fwd_hit  = 1'b1;
        fwd_data = ent_data[fidx[k]];
      end
    end
  end

endmodule

// File: tb/tb_store_buffer.sv
// Self-checking bench for store_buffer: scoreboard of accepted stores, retired in order
// against memory writes, plus a reference model for readiness, forwarding and empty.
module tb_store_buffer;
  import store_buffer_pkg::*;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned AW    = 16;
  localparam int unsigned DW    = 16;

  logic          CLK = 1'b0;
  logic          Reset;
  logic          st_valid;
  logic [AW-1:0] st_addr;
  logic [DW-1:0] st_data;
  logic          st_ready;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic          mem_ack;
  logic [AW-1:0] rd_addr;
  logic          fwd_hit;
  logic [DW-1:0] fwd_data;
  logic          empty;

  always #5 CLK = ~CLK;

  store_buffer #(
    .DEPTH (DEPTH),
    .AW    (AW),
    .DW    (DW)
  ) dut (
    .CLK       (CLK),
    .Reset     (Reset),
    .st_valid  (st_valid),
    .st_addr   (st_addr),
    .st_data   (st_data),
    .st_ready  (st_ready),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_ack   (mem_ack),
    .rd_addr   (rd_addr),
    .fwd_hit   (fwd_hit),
    .fwd_data  (fwd_data),
    .empty     (empty)
  );

  int          n_checks = 0;
  int          n_errors = 0;
  int          writes   = 0;
  logic [31:0] exp_q[$];   // pending stores {addr, data}, oldest first
  logic        m_write  = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // One clock: compare outputs mid-cycle, then advance model at the rising edge.
  task automatic cycle();
    logic        acc, pop, hit;
    logic [15:0] fd;
    #1;
    hit = 1'b0;
    fd  = '0;
    for (int i = exp_q.size() - 1; i >= 0; i--) begin
      if (exp_q[i][31:16] == rd_addr) begin
        hit = 1'b1;
        fd  = exp_q[i][15:0];
        break;
      end
    end
    check("st_ready", 32'(st_ready), 32'(exp_q.size() != DEPTH));
    check("mem_we", 32'(mem_we), 32'(m_write));
    check("empty", 32'(empty), 32'(exp_q.size() == 0 && !m_write));
    check("fwd_hit", 32'(fwd_hit), 32'(hit));
    check("fwd_data", 32'(fwd_data), 32'(fd));
    acc = st_valid && (exp_q.size() < DEPTH) && !Reset;
    pop = 1'b0;
    if (mem_we) begin
      if (exp_q.size() == 0) begin
        check("phantom_write", 32'(mem_addr), 32'hffff_ffff);
      end else begin
        check("wr_addr", 32'(mem_addr), 32'(exp_q[0][31:16]));
        check("wr_data", 32'(mem_wdata), 32'(exp_q[0][15:0]));
        pop = mem_ack;
      end
    end else begin
      check("idle_addr", 32'(mem_addr), 32'h0);
      check("idle_data", 32'(mem_wdata), 32'h0);
    end
    @(posedge CLK);
    if (Reset) begin
      exp_q.delete();
      m_write = 1'b0;
    end else begin
      if (pop) begin
        void'(exp_q.pop_front());
        writes++;
      end
      if (acc) exp_q.push_back({st_addr, st_data});
      m_write = (exp_q.size() != 0);
    end
    @(negedge CLK);
  endtask

  task automatic push_one(input logic [15:0] a, input logic [15:0] d, input logic ack);
    st_valid = 1'b1;
    st_addr  = a;
    st_data  = d;
    mem_ack  = ack;
    cycle();
    st_valid = 1'b0;
  endtask

  task automatic drain();
    st_valid = 1'b0;
    mem_ack  = 1'b1;
    for (int i = 0; i < 40 && (exp_q.size() != 0 || m_write); i++) cycle();
    check("drained", 32'(exp_q.size()), 32'h0);
    mem_ack = 1'b0;
    cycle();
  endtask

  initial begin
    int w0, pushed, guard;
    logic will_acc;
    Reset = 1'b1; st_valid = 1'b0; st_addr = '0; st_data = '0; mem_ack = 1'b0; rd_addr = 16'hffff;
    @(posedge CLK);
    @(posedge CLK);
    @(negedge CLK);
    Reset = 1'b0;
    cycle();  // reset values against an empty model

    // Single store, immediate ack.
    push_one(16'h0010, 16'hbeef, 1'b1);
    #1;
    check("t1_we", 32'(mem_we), 32'h1);
    check("t1_addr", 32'(mem_addr), 32'h0010);
    check("t1_data", 32'(mem_wdata), 32'hbeef);
    cycle();
    #1;
    check("t1_empty", 32'(empty), 32'h1);
    cycle();

    // Fill to full, reject a fifth store, then retire back to back.
    for (int i = 0; i < 4; i++) push_one(16'h0020 + 16'(i), 16'h0a00 + 16'(i), 1'b0);
    #1;
    check("t2_full", 32'(st_ready), 32'h0);
    push_one(16'h0024, 16'h0a04, 1'b0);
    mem_ack = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      check("t2_seq_we", 32'(mem_we), 32'h1);
      check("t2_seq_addr", 32'(mem_addr), 32'h0020 + 32'(i));
      cycle();
    end
    drain();

    // Forwarding picks the youngest match.
    push_one(16'h0040, 16'h1111, 1'b0);
    push_one(16'h0040, 16'h2222, 1'b0);
    rd_addr = 16'h0040;
    #1;
    check("t3_hit", 32'(fwd_hit), 32'h1);
    check("t3_data", 32'(fwd_data), 32'h2222);
    cycle();
    rd_addr = 16'h0041;
    #1;
    check("t3_miss", 32'(fwd_hit), 32'h0);
    check("t3_miss_data", 32'(fwd_data), 32'h0);
    cycle();
    rd_addr = 16'hffff;
    drain();

    // Simultaneous push and pop with two entries queued.
    push_one(16'h0050, 16'h5050, 1'b0);
    push_one(16'h0051, 16'h5151, 1'b0);
    push_one(16'h0052, 16'h5252, 1'b1);
    mem_ack = 1'b0;
    check("t4_count", 32'(exp_q.size()), 32'h2);
    cycle();
    w0 = writes;
    drain();
    check("t4_retired", 32'(writes - w0), 32'h2);

    // Reset mid-write discards everything; later acks cause no writes.
    for (int i = 0; i < 3; i++) push_one(16'h0060 + 16'(i), 16'h6000 + 16'(i), 1'b0);
    Reset = 1'b1;
    cycle();
    Reset = 1'b0;
    #1;
    check("t5_we", 32'(mem_we), 32'h0);
    check("t5_empty", 32'(empty), 32'h1);
    check("t5_ready", 32'(st_ready), 32'h1);
    w0 = writes;
    mem_ack = 1'b1;
    for (int i = 0; i < 3; i++) cycle();
    mem_ack = 1'b0;
    check("t5_no_writes", 32'(writes - w0), 32'h0);

    // Wrap-around with random ack gaps.
    w0 = writes;
    pushed = 0;
    guard = 0;
    while (pushed < 10 && guard < 200) begin
      st_valid = 1'b1;
      st_addr  = 16'h0100 + 16'(pushed);
      st_data  = 16'(pushed);
      mem_ack  = 1'($urandom_range(0, 1));
      will_acc = (exp_q.size() < DEPTH);
      cycle();
      if (will_acc) pushed++;
      guard++;
    end
    check("t6_pushed", 32'(pushed), 32'd10);
    st_valid = 1'b0;
    guard = 0;
    while ((exp_q.size() != 0 || m_write) && guard < 200) begin
      mem_ack = 1'($urandom_range(0, 1));
      cycle();
      guard++;
    end
    check("t6_retired", 32'(writes - w0), 32'd10);
    drain();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "simulation did not finish");
  end

endmodule
